// File: rtl/mac_l1_pkg.sv
// Shared types for the L1 MAC transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// WORD_W    : delay-line word width
// ID_MAX_W  : sideband id field width, sized for the largest supported N_REQ (8)
// arb_state_e / sideband_t : arbiter FSM state and the per-word sideband
package mac_l1_pkg;

  localparam int WORD_W   = 16;
  localparam int ID_MAX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic                last;
    logic [ID_MAX_W-1:0] id;
  } sideband_t;

endpackage

// File: rtl/mac_l1_rr_pick.sv
// Masked round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
//
// req        : request vector
// ptr        : highest-priority index for this pick
// gnt_onehot : one-hot winner (all zero when no request)
// gnt_id     : binary winner index
// any        : at least one request present
module mac_l1_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  int              idx;
  logic [ID_W-1:0] idx_sel;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    idx_sel    = '0;
    // Scan N_REQ positions starting at ptr; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_sel = ID_W'(idx);
      if (!any && req[idx_sel]) begin
        any                 = 1'b1;
        gnt_onehot[idx_sel] = 1'b1;
        gnt_id              = idx_sel;
      end
    end
  end

endmodule

// File: rtl/mac_l1_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding the L1 MAC 16-bit delay line.
// Latency: accepted word on line_data 1 cycle later; valid/last/id sideband out DEPTH cycles after that.
// Backpressure: req_ready only to the granted requester while BUSY; no backpressure from the line.
//
// Optional feature macro: MAC_L1_ARB_TIMEOUT_EN (mid-frame stall timeout with abort pulse).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_last/req_data      per-requester word, requester i data at [16*i+15:16*i]
//   req_ready                        one-hot ready to the granted requester
//   line_data/line_valid             word into the delay line
//   out_valid/out_last/out_id        sideband aligned with the delay line output
//   busy                             a frame is granted
//   abort                            one-cycle timeout abort pulse (0 when macro undefined)
module mac_l1_tx_arbiter
  import mac_l1_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  DEPTH   = 6,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [WORD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]       line_data,
  output logic                    line_valid,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy,
  output logic                    abort
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WORD_W-1:0]   line_data_q, line_data_d;
  sideband_t           line_sb_q, line_sb_d;
  sideband_t           pipe_q [DEPTH];
  sideband_t           pipe_d [DEPTH];

  logic [N_REQ-1:0]    pick_onehot_unused;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;

  logic                grant_valid;
  logic                grant_last;
  logic [WORD_W-1:0]   grant_word;
  logic                xfer;
  logic [ID_W-1:0]     ptr_after_grant;
  logic                timeout_hit;
  logic [ID_MAX_W-1:0] unused_sb_id;

  mac_l1_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (pick_onehot_unused),
    .gnt_id     (pick_id),
    .any        (pick_any)
  );

  // Select the granted requester's inputs; ready decodes the held grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    grant_word  = '0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        grant_valid  = req_valid[i];
        grant_last   = req_last[i];
        grant_word   = req_data[i*WORD_W +: WORD_W];
        req_ready[i] = (state_q == BUSY);
      end
    end
  end

  assign xfer            = (state_q == BUSY) && grant_valid;
  assign ptr_after_grant = (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + ID_W'(1);

`ifdef MAC_L1_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counter holds the number of stall cycles already elapsed, so the
  // TIMEOUT-th consecutive stall cycle is the one that sees TIMEOUT-1.
  assign timeout_hit = (state_q == BUSY) && !grant_valid &&
                       (stall_cnt_q == STALL_W'(TIMEOUT - 1));

  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == BUSY) && !grant_valid && !timeout_hit)
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  assign abort = timeout_hit;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    line_data_d = line_data_q;

    line_sb_d.valid = xfer;
    line_sb_d.last  = xfer && grant_last;
    line_sb_d.id    = xfer ? ID_MAX_W'(grant_q) : '0;

    unique case (state_q)
      IDLE: begin
        // Grant is only registered here; the first transfer is one cycle later,
        // which is what guarantees an idle cycle between frames.
        if (pick_any) begin
          grant_d = pick_id;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          line_data_d = grant_word;
          if (grant_last) begin
            state_d = IDLE;
            ptr_d   = ptr_after_grant;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          ptr_d   = ptr_after_grant;
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_d[0] = line_sb_q;
    for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      line_data_q <= '0;
      line_sb_q   <= '0;
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      line_data_q <= line_data_d;
      line_sb_q   <= line_sb_d;
      pipe_q      <= pipe_d;
    end
  end

  assign busy         = (state_q == BUSY);
  assign line_data    = line_data_q;
  assign line_valid   = line_sb_q.valid;
  assign out_valid    = pipe_q[DEPTH-1].valid;
  assign out_last     = pipe_q[DEPTH-1].last;
  assign out_id       = pipe_q[DEPTH-1].id[ID_W-1:0];
  assign unused_sb_id = pipe_q[DEPTH-1].id;

endmodule

// File: tb/tb_mac_l1_tx_arbiter.sv
// Self-checking bench for mac_l1_tx_arbiter.
// Expected words are queued when a transfer is driven and compared as the line and pipe outputs appear.
// Works with and without MAC_L1_ARB_TIMEOUT_EN.
module tb_mac_l1_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DEPTH   = 6;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_last;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_ready;
  logic [15:0]       line_data;
  logic              line_valid;
  logic              out_valid;
  logic              out_last;
  logic [1:0]        out_id;
  logic              busy;
  logic              abort;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  id;
  } exp_t;

  exp_t line_q [$];
  exp_t out_q  [$];
  int   out_t_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  mac_l1_tx_arbiter #(
    .N_REQ   (N_REQ),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .line_data  (line_data),
    .line_valid (line_valid),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_id     (out_id),
    .busy       (busy),
    .abort      (abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output monitor: line words against the driven expectation, then the
  // sideband exactly DEPTH cycles after the word reached the line.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   t;
    if (rst_n) begin
      if (line_valid) begin
        chk_cnt++;
        if (line_q.size() == 0) begin
          $display("FAIL line_unexpected: line_data=%h with nothing expected", line_data);
        end else begin
          e = line_q.pop_front();
          if (line_data !== e.data)
            $display("FAIL line_data: got %h expected %h", line_data, e.data);
          else pass_cnt++;
          out_q.push_back(e);
          out_t_q.push_back(cyc + DEPTH);
        end
      end
      if (out_valid) begin
        chk_cnt++;
        if (out_q.size() == 0) begin
          $display("FAIL out_unexpected: out_valid with nothing expected (id=%0d last=%b)", out_id, out_last);
        end else begin
          e = out_q.pop_front();
          t = out_t_q.pop_front();
          if (out_last !== e.last || out_id !== e.id || cyc !== t)
            $display("FAIL out_sideband: got last=%b id=%0d cyc=%0d expected last=%b id=%0d cyc=%0d",
                     out_last, out_id, cyc, e.last, e.id, t);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    line_q.delete();
    out_q.delete();
    out_t_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    flush_queues();
    rst_n = 1'b1;
  endtask

  // Present one word on requester i and hold it until accepted (bounded).
  // Returns at the sample point just after the accepting edge.
  task automatic send_word(input int i, input logic [15:0] d, input logic l);
    int n;
    n = 0;
    req_valid[i]          = 1'b1;
    req_data[16*i +: 16]  = d;
    req_last[i]           = l;
    while (!req_ready[i] && n < 50) begin
      step();
      n++;
    end
    if (!req_ready[i]) begin
      chk_cnt++;
      $display("FAIL send_timeout: req%0d never got ready (ready=%b), required ready", i, req_ready);
    end else begin
      line_q.push_back('{data: d, last: l, id: 2'(i)});
    end
    step();
    req_valid[i] = 1'b0;
    req_last[i]  = 1'b0;
  endtask

  task automatic test_reset();
    logic [N_REQ-1:0] exp_rdy;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    step();
    step();
    chk_cnt++;
    if ({req_ready, line_data, line_valid, out_valid, out_last, out_id, busy, abort} !== '0)
      $display("FAIL reset_outputs: got ready=%b line=%h lv=%b ov=%b ol=%b oid=%0d busy=%b abort=%b, required all 0",
               req_ready, line_data, line_valid, out_valid, out_last, out_id, busy, abort);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    // Complete a frame on req2 (pointer moves to 3), then start req3 and reset mid-frame.
    send_word(2, 16'h2A2A, 1'b1);
    send_word(3, 16'h3B3B, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    flush_queues();
    chk_cnt++;
    if ({req_ready, line_data, line_valid, out_valid, out_last, out_id, busy, abort} !== '0)
      $display("FAIL reset_midframe: got ready=%b line=%h lv=%b busy=%b, required all 0",
               req_ready, line_data, line_valid, busy);
    else pass_cnt++;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    // Both 2 and 3 request; a cleared pointer scans from 0 and picks 2.
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    req_data[16*3 +: 16] = 16'h3D3D;
    req_last[3]  = 1'b1;
    step();
    exp_rdy = 4'b0100;
    chk_cnt++;
    if (req_ready !== exp_rdy || busy !== 1'b1)
      $display("FAIL reset_grant: got ready=%b busy=%b, required ready=%b busy=1", req_ready, busy, exp_rdy);
    else pass_cnt++;
    send_word(2, 16'h2C2C, 1'b1);
    send_word(3, 16'h3D3D, 1'b1);
  endtask

  task automatic test_single_frame();
    logic [15:0] words [3];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b required 0", busy);
    else pass_cnt++;
    for (int w = 0; w < 3; w++) begin
      send_word(0, words[w], (w == 2));
      chk_cnt++;
      if (line_valid !== 1'b1 || line_data !== words[w])
        $display("FAIL single_line_t1: word %0d got lv=%b data=%h required lv=1 data=%h",
                 w, line_valid, line_data, words[w]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL single_end_busy: got busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int               n;
    int               exp_g;
    logic [N_REQ-1:0] exp_rdy;
    logic [15:0]      d;
    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int k = 0; k < 5; k++) begin
      exp_g = k % N_REQ;
      for (int i = 0; i < N_REQ; i++) req_data[16*i +: 16] = 16'(16'hA000 + k*16 + i);
      n = 0;
      while (req_ready == '0 && n < 20) begin
        step();
        n++;
      end
      exp_rdy = '0;
      exp_rdy[exp_g] = 1'b1;
      chk_cnt++;
      if (req_ready !== exp_rdy)
        $display("FAIL rr_order: frame %0d got ready=%b required %b", k, req_ready, exp_rdy);
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (n !== 1) $display("FAIL rr_gap: frame %0d got %0d idle cycles required 1", k, n);
        else pass_cnt++;
      end
      d = 16'(16'hA000 + k*16 + exp_g);
      line_q.push_back('{data: d, last: 1'b1, id: 2'(exp_g)});
      step();
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_stall();
    logic [N_REQ-1:0] exp_rdy;
    exp_rdy = 4'b0010;
    req_valid[2] = 1'b1;
    req_data[16*2 +: 16] = 16'h5555;
    send_word(1, 16'h1001, 1'b0);
    for (int b = 0; b < 5; b++) begin
      step();
      chk_cnt++;
      if (line_valid !== 1'b0 || line_data !== 16'h1001)
        $display("FAIL stall_bubble: cycle %0d got lv=%b data=%h required lv=0 data=1001", b, line_valid, line_data);
      else pass_cnt++;
      chk_cnt++;
      if (req_ready !== exp_rdy)
        $display("FAIL stall_ready: cycle %0d got ready=%b required %b", b, req_ready, exp_rdy);
      else pass_cnt++;
    end
    send_word(1, 16'h1002, 1'b1);
    req_valid[2] = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL stall_end: got busy=%b required 0", busy);
    else pass_cnt++;
  endtask

`ifdef MAC_L1_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [N_REQ-1:0] exp_rdy;
    send_word(3, 16'h3E01, 1'b0);
    for (int s = 1; s <= TIMEOUT; s++) begin
      chk_cnt++;
      if (abort !== (s == TIMEOUT) || busy !== 1'b1)
        $display("FAIL timeout_abort: stall %0d got abort=%b busy=%b required abort=%b busy=1",
                 s, abort, busy, (s == TIMEOUT));
      else pass_cnt++;
      if (s < TIMEOUT) step();
    end
    step();
    chk_cnt++;
    if (busy !== 1'b0 || abort !== 1'b0)
      $display("FAIL timeout_after: got busy=%b abort=%b required 0 0", busy, abort);
    else pass_cnt++;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    step();
    exp_rdy = 4'b0001;
    chk_cnt++;
    if (req_ready !== exp_rdy)
      $display("FAIL timeout_next_grant: got ready=%b required %b", req_ready, exp_rdy);
    else pass_cnt++;
    send_word(0, 16'h0E01, 1'b1);
    req_valid[3] = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    int abort_seen;
    int busy_low;
    abort_seen = 0;
    busy_low   = 0;
    send_word(3, 16'h3E01, 1'b0);
    for (int s = 1; s <= 200; s++) begin
      if (abort !== 1'b0) abort_seen++;
      if (busy !== 1'b1) busy_low++;
      step();
    end
    chk_cnt++;
    if (abort_seen !== 0) $display("FAIL no_timeout_abort: got %0d abort cycles required 0", abort_seen);
    else pass_cnt++;
    chk_cnt++;
    if (busy_low !== 0) $display("FAIL no_timeout_busy: got %0d busy-low cycles required 0", busy_low);
    else pass_cnt++;
    send_word(3, 16'h3E02, 1'b1);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL no_timeout_end: got busy=%b required 0", busy);
    else pass_cnt++;
  endtask
`endif

  task automatic test_drain();
    repeat (DEPTH + 4) step();
    chk_cnt++;
    if (line_q.size() !== 0 || out_q.size() !== 0)
      $display("FAIL drain: %0d line and %0d sideband entries outstanding, required 0 0",
               line_q.size(), out_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
`ifdef MAC_L1_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
